instr_sequencer: RTL and testbench

//  Upstream instruction source for the control unit. Holds a small loadable program memory and drives
//  the shared DIN word and the run line. Steps through the program one instruction per done pulse.

---
 rtl/instr_sequencer.sv | 111 +++++++++++
 tb/tb_instr_sequencer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// Instruction sequencer: loadable program memory feeding DIN/run to the control unit,
// one instruction per done pulse, halt on opcode 111, watchdog on a missing done.
module instr_sequencer #(
    parameter  int DEPTH   = 16,
    parameter  int TIMEOUT = 8,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          start,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    input  logic [8:0]    load_data,
    input  logic          done,
    output logic          run,
    output logic [8:0]    din,
    output logic [AW-1:0] pc,
    output logic          busy,
    output logic          halted,
    output logic          timeout_err,
    output logic [15:0]   retired
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [2:0] OP_MVI  = 3'b100;
    localparam logic [2:0] OP_HALT = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_HALTED,
        S_ERROR
    } state_t;

    state_t          r_state;
    logic [AW-1:0]   r_pc;
    logic [15:0]     r_retired;
    logic [CW-1:0]   r_exec_cnt;
    logic [2:0]      r_op;
    logic [8:0]      r_mem [DEPTH];

    logic [8:0]      w_word;
    logic            w_is_halt;
    logic            w_busy;

    assign w_word    = r_mem[r_pc];
    assign w_is_halt = (w_word[8:6] == OP_HALT);
    assign w_busy    = (r_state == S_FETCH) || (r_state == S_EXEC);

    assign run         = ((r_state == S_FETCH) && !w_is_halt) || (r_state == S_EXEC);
    assign din         = w_word;
    assign pc          = r_pc;
    assign busy        = w_busy;
    assign halted      = (r_state == S_HALTED);
    assign timeout_err = (r_state == S_ERROR);
    assign retired     = r_retired;

    // Program memory survives reset; writes are locked out while an instruction is in flight.
    always_ff @(posedge clk) begin
        if (load_en && !w_busy) begin
            r_mem[load_addr] <= load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state    <= S_IDLE;
            r_pc       <= '0;
            r_retired  <= '0;
            r_exec_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_HALTED, S_ERROR: begin
                    if (start) begin
                        r_pc      <= '0;
                        r_retired <= '0;
                        r_state   <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (w_is_halt) begin
                        r_state <= S_HALTED;
                    end else begin
                        r_op       <= w_word[8:6];
                        r_pc       <= r_pc + 1'b1;
                        r_exec_cnt <= '0;
                        r_state    <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_exec_cnt <= r_exec_cnt + 1'b1;
                    if (done) begin
                        if (r_retired != 16'hFFFF) begin
                            r_retired <= r_retired + 16'd1;
                        end
                        // MVI consumed the word at pc as its immediate, so step over it.
                        if (r_op == OP_MVI) begin
                            r_pc <= r_pc + 1'b1;
                        end
                        r_state <= S_FETCH;
                    end else if (r_exec_cnt == CW'(TIMEOUT - 1)) begin
                        r_state <= S_ERROR;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: walks the program with a behavioural model to build an
// expected per-cycle trace, acts as the control unit, and compares every cycle.
module tb_instr_sequencer;

    localparam int DEPTH   = 16;
    localparam int TIMEOUT = 8;
    localparam int AW      = 4;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          start = 1'b0;
    logic          load_en = 1'b0;
    logic [AW-1:0] load_addr = '0;
    logic [8:0]    load_data = '0;
    logic          done = 1'b0;
    logic          run;
    logic [8:0]    din;
    logic [AW-1:0] pc;
    logic          busy;
    logic          halted;
    logic          timeout_err;
    logic [15:0]   retired;

    int total = 0;
    int bad   = 0;

    logic [8:0] mem_m [DEPTH];
    bit         force_junk = 1'b0;

    typedef struct {
        logic [32:0] exp;
        logic        d;
    } ent_t;
    ent_t trace[$];

    instr_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .resetn(resetn), .start(start), .load_en(load_en),
        .load_addr(load_addr), .load_data(load_data), .done(done),
        .run(run), .din(din), .pc(pc), .busy(busy), .halted(halted),
        .timeout_err(timeout_err), .retired(retired)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic chk_eq(input string tag, input logic [32:0] got, input logic [32:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // {run, din, pc, busy, halted, timeout_err, retired}
    function automatic logic [32:0] pack(input logic r, input logic [8:0] w, input logic [AW-1:0] p,
                                         input logic b, input logic h, input logic e,
                                         input logic [15:0] n);
        return {r, w, p, b, h, e, n};
    endfunction

    function automatic logic [32:0] obs();
        return {run, din, pc, busy, halted, timeout_err, retired};
    endfunction

    function automatic void push(input logic [32:0] e, input logic d);
        ent_t t;
        t.exp = e;
        t.d   = d;
        trace.push_back(t);
    endfunction

    // Walk the program instruction by instruction; done latency is 2 for MV/MVI-like, 3 for ADD/SUB.
    function automatic void build_trace(input int hang_idx);
        logic [AW-1:0] p = '0;
        logic [AW-1:0] q;
        logic [15:0]   r = '0;
        logic [8:0]    w;
        int            n = 0;
        int            lat;
        trace.delete();
        while (1) begin
            w = mem_m[p];
            if (w[8:6] == 3'b111) begin
                push(pack(1'b0, w, p, 1'b1, 1'b0, 1'b0, r), 1'($urandom));
                for (int k = 0; k < 3; k++)
                    push(pack(1'b0, w, p, 1'b0, 1'b1, 1'b0, r), (k == 0) ? 1'b1 : 1'($urandom));
                return;
            end
            push(pack(1'b1, w, p, 1'b1, 1'b0, 1'b0, r), 1'($urandom));
            q = p + 1'b1;
            if (n == hang_idx || n >= 40) begin
                for (int k = 0; k < TIMEOUT; k++)
                    push(pack(1'b1, mem_m[q], q, 1'b1, 1'b0, 1'b0, r), 1'b0);
                for (int k = 0; k < 3; k++)
                    push(pack(1'b0, mem_m[q], q, 1'b0, 1'b0, 1'b1, r), (k == 0) ? 1'b1 : 1'($urandom));
                return;
            end
            lat = (w[8:6] == 3'b010 || w[8:6] == 3'b011) ? 3 : 2;
            for (int k = 1; k <= lat; k++)
                push(pack(1'b1, mem_m[q], q, 1'b1, 1'b0, 1'b0, r), (k == lat));
            r = (r == 16'hFFFF) ? r : r + 16'd1;
            p = (w[8:6] == 3'b100) ? q + 1'b1 : q;
            n++;
        end
    endfunction

    task automatic load(input logic [AW-1:0] a, input logic [8:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        mem_m[a]  = d;
        @(posedge clk); #1;
        load_en = 1'b0;
    endtask

    task automatic run_prog(input string tag, input int hang_idx, input bit st_load);
        logic [AW-1:0] a;
        logic [8:0]    dv;
        if (st_load) begin
            a         = AW'($urandom_range(0, DEPTH - 1));
            dv        = 9'($urandom);
            mem_m[a]  = dv;
            load_en   = 1'b1;
            load_addr = a;
            load_data = dv;
        end
        build_trace(hang_idx);
        start = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
        load_en = 1'b0;
        foreach (trace[i]) begin
            chk_eq($sformatf("%s[%0d]", tag, i), obs(), trace[i].exp);
            done = trace[i].d;
            if (trace[i].exp[18]) begin
                load_en   = force_junk ? 1'b1 : 1'($urandom);
                load_addr = force_junk ? AW'(2) : AW'($urandom_range(0, DEPTH - 1));
                load_data = force_junk ? 9'h1C0 : 9'($urandom);
            end else begin
                load_en = 1'b0;
            end
            @(posedge clk); #1;
        end
        done    = 1'b0;
        load_en = 1'b0;
    endtask

    initial begin
        logic [8:0] w;
        int         hang;
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_eq("reset_ctl", 33'({run, pc, busy, halted, timeout_err, retired}), 33'd0);
        resetn = 1'b1;

        done = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        done = 1'b0;
        chk_eq("idle_done", 33'({run, pc, busy, halted, timeout_err, retired}), 33'd0);

        for (int i = 0; i < DEPTH; i++) load(AW'(i), 9'h1C0);

        load(0, 9'h100); load(1, 9'h005); load(2, 9'h048); load(3, 9'h1C0);
        run_prog("progA", -1, 1'b0);
        chk_eq("progA_pc", 33'(pc), 33'd3);
        chk_eq("progA_retired", 33'(retired), 33'd2);
        chk_eq("progA_halt_run", 33'({halted, run}), 33'b10);

        load(0, 9'h090);
        run_prog("hang", 0, 1'b0);
        chk_eq("hang_state", 33'({timeout_err, run, busy}), 33'b100);
        chk_eq("hang_pc", 33'(pc), 33'd1);
        run_prog("hang_restart", 0, 1'b0);

        load(0, 9'h100); load(1, 9'h1C0); load(15, 9'h100);
        for (int i = 2; i < 15; i++) load(AW'(i), 9'h048);
        run_prog("wrap", -1, 1'b0);
        chk_eq("wrap_pc", 33'(pc), 33'd1);
        chk_eq("wrap_retired", 33'(retired), 33'd15);

        load(0, 9'h090); load(1, 9'h1C0); load(2, 9'h048); load(3, 9'h1C0);
        force_junk = 1'b1;
        run_prog("busy_load", -1, 1'b0);
        force_junk = 1'b0;
        load(1, 9'h000);
        run_prog("halt_load", -1, 1'b0);
        chk_eq("halt_load_pc", 33'(pc), 33'd3);

        load(0, 9'h100); load(1, 9'h005); load(2, 9'h048); load(3, 9'h1C0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        chk_eq("mid_exec_busy", 33'({busy, run}), 33'b11);
        resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        chk_eq("mid_exec_reset", obs(), pack(1'b0, mem_m[0], '0, 1'b0, 1'b0, 1'b0, 16'd0));
        run_prog("rerun", -1, 1'b0);

        for (int t = 0; t < 20; t++) begin
            for (int i = 0; i < DEPTH; i++) begin
                w = 9'($urandom);
                if ($urandom_range(0, 7) == 0) w[8:6] = 3'b111;
                else if (w[8:6] == 3'b111) w[8:6] = 3'b000;
                load(AW'(i), w);
            end
            hang = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 10)) : -1;
            run_prog($sformatf("rnd%0d", t), hang, 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
